mem_bus_unit: RTL and testbench

MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

---
 rtl/mem_bus_unit.sv | 110 +++++++++++
 tb/tb_mem_bus_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_unit.sv
// Memory bus unit: MAR/MDR registers, bus drive and a single-outstanding memory
// handshake with a 16-cycle timeout and a sticky error flag.
module mem_bus_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic        ldmar,
    input  logic        ldmdr,
    input  logic        tmar,
    input  logic        tmdr,
    input  logic        memrd,
    input  logic        memwr,
    output logic [15:0] bus_out,
    output logic        bus_oe,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StReq, StDone, StTout} state_e;

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Next-state: register loads only in IDLE, request handshake and timeout in REQ.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (ldmar) mar_d = bus_in;
                if (ldmdr) mdr_d = bus_in;
                if (memrd ^ memwr) begin
                    state_d = StReq;
                    we_d    = memwr;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                end else if (memrd && memwr) begin
                    // Conflicting strobes: refuse the request and flag it.
                    err_d = 1'b1;
                end
            end
            StReq: begin
                // Ack is checked before the limit so an ack on the 16th cycle still succeeds.
                if (mem_ack) begin
                    state_d = StDone;
                    if (!we_q) mdr_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = StTout;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StTout:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state plus the combinational bus drive (tmdr wins).
    always_comb begin
        mem_req   = (state_q == StReq);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone) || (state_q == StTout);
        err       = err_q;
        mem_we    = we_q;
        mem_addr  = mar_q;
        mem_wdata = mdr_q;
        bus_oe    = tmar | tmdr;
        bus_out   = 16'h0000;
        if (tmdr)      bus_out = mdr_q;
        else if (tmar) bus_out = mar_q;
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: the driver pushes the expected outcome of each
// transaction, a monitor checks every request cycle and every done pulse.
module tb_mem_bus_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ldmar, ldmdr, tmar, tmdr, memrd, memwr;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic        busy, done, err;

    mem_bus_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_in   (bus_in),
        .ldmar    (ldmar),
        .ldmdr    (ldmdr),
        .tmar     (tmar),
        .tmdr     (tmdr),
        .memrd    (memrd),
        .memwr    (memwr),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] mar;
        logic [15:0] mdr_before;
        logic [15:0] mdr_after;
        int          cycles;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model of the architectural state.
    logic [15:0] m_mar = 16'h0;
    logic [15:0] m_mdr = 16'h0;
    logic        m_err = 1'b0;

    // Memory responder configuration.
    int          ack_k = 99;
    logic [15:0] rd_data = 16'h0;
    int          rcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ack on REQ cycle ack_k (0-based); stray acks/garbage outside REQ.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = (rcnt == ack_k);
            mem_rdata = rd_data;
            rcnt++;
        end else begin
            rcnt      = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor: checks request-phase outputs and pops one expectation per done pulse.
    initial begin
        int   req_cycles;
        exp_t e;
        req_cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                req_cycles = 0;
                continue;
            end
            if (mem_req) begin
                req_cycles++;
                chk("req_has_txn", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("mem_addr", 32'(mem_addr), 32'(sb[0].mar));
                    chk("mem_we", 32'(mem_we), 32'(sb[0].we));
                    chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].mdr_before));
                end
            end
            if (done) begin
                chk("done_has_txn", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("req_cycles", 32'(req_cycles), 32'(e.cycles));
                    chk("done_err", 32'(err), 32'(e.err));
                    chk("done_mdr", 32'(mem_wdata), 32'(e.mdr_after));
                    chk("done_mar", 32'(mem_addr), 32'(e.mar));
                    chk("done_mem_req", 32'(mem_req), 0);
                end
                req_cycles = 0;
            end
        end
    end

    task automatic load(input bit to_mar, input logic [15:0] v);
        @(negedge clk);
        bus_in = v;
        if (to_mar) begin ldmar = 1'b1; m_mar = v; end
        else begin ldmdr = 1'b1; m_mdr = v; end
        @(posedge clk);
        #1;
        ldmar = 1'b0;
        ldmdr = 1'b0;
    endtask

    task automatic bus_check(input bit a, input bit d);
        logic [15:0] ev;
        @(negedge clk);
        tmar = a;
        tmdr = d;
        #1;
        ev = d ? m_mdr : (a ? m_mar : 16'h0);
        chk("bus_out", 32'(bus_out), 32'(ev));
        chk("bus_oe", 32'(bus_oe), 32'(a | d));
        tmar = 1'b0;
        tmdr = 1'b0;
    endtask

    // One transaction from IDLE; k > 15 means the memory never acks.
    task automatic do_txn(input bit rd, input int k, input logic [15:0] rdata, input bit noise);
        exp_t e;
        bit   ok;
        @(negedge clk);
        chk("idle_before_txn", 32'(busy), 0);
        e.we         = !rd;
        e.mar        = m_mar;
        e.mdr_before = m_mdr;
        e.cycles     = (k <= 15) ? k + 1 : 16;
        e.err        = (k > 15);
        e.mdr_after  = (k <= 15 && rd) ? rdata : m_mdr;
        sb.push_back(e);
        m_mdr   = e.mdr_after;
        m_err   = e.err;
        ack_k   = k;
        rd_data = rdata;
        memrd   = rd;
        memwr   = !rd;
        ok      = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            memrd = 1'b0;
            memwr = 1'b0;
            ldmar = 1'b0;
            ldmdr = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            // Strobes while busy must all be ignored.
            if (noise) begin
                bus_in = 16'($urandom);
                ldmar  = 1'($urandom_range(0, 1));
                ldmdr  = 1'($urandom_range(0, 1));
                memrd  = 1'($urandom_range(0, 1));
                memwr  = 1'($urandom_range(0, 1));
            end
        end
        chk("txn_completes", 32'(ok), 1);
        chk("err_after_txn", 32'(err), 32'(m_err));
    endtask

    initial begin
        rst_n = 1'b0;
        bus_in = 16'h0; ldmar = 1'b0; ldmdr = 1'b0; tmar = 1'b0; tmdr = 1'b0;
        memrd = 1'b0; memwr = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_bus_oe", 32'(bus_oe), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read with immediate ack, then drive MDR onto the bus.
        load(1'b1, 16'h1234);
        do_txn(1'b1, 0, 16'hBEEF, 1'b0);
        bus_check(1'b0, 1'b1);

        // Write with three wait states.
        load(1'b0, 16'h00A5);
        load(1'b1, 16'h0010);
        do_txn(1'b0, 3, 16'h5555, 1'b0);
        bus_check(1'b0, 1'b1);

        // Timeout, then a following read clears err; ack on the 16th cycle succeeds.
        do_txn(1'b1, 16, 16'h1111, 1'b0);
        do_txn(1'b1, 2, 16'h2222, 1'b0);
        do_txn(1'b0, 15, 16'h3333, 1'b1);

        // Conflicting strobes in IDLE.
        @(negedge clk);
        memrd = 1'b1;
        memwr = 1'b1;
        @(negedge clk);
        memrd = 1'b0;
        memwr = 1'b0;
        m_err = 1'b1;
        #1;
        chk("proto_err", 32'(err), 1);
        chk("proto_busy", 32'(busy), 0);
        chk("proto_mem_req", 32'(mem_req), 0);
        bus_check(1'b1, 1'b1);
        bus_check(1'b1, 1'b0);

        // Randomised traffic with noise while busy.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) load(1'b1, 16'($urandom));
            if ($urandom_range(0, 1) == 1) load(1'b0, 16'($urandom));
            bus_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 17)), 16'($urandom), 1'b1);
        end

        // Reset in the middle of a request.
        load(1'b1, 16'hCAFE);
        load(1'b0, 16'hF00D);
        @(negedge clk);
        sb.push_back('{we: 1'b0, mar: m_mar, mdr_before: m_mdr, mdr_after: m_mdr,
                       cycles: 0, err: 1'b0});
        ack_k = 99;
        memrd = 1'b1;
        @(negedge clk);
        memrd = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreq_active", 32'(mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_mar", 32'(mem_addr), 0);
        chk("arst_mdr", 32'(mem_wdata), 0);
        sb.delete();
        m_mar = 16'h0;
        m_mdr = 16'h0;
        m_err = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 0);
        end
        do_txn(1'b1, 1, 16'h7777, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "time limit");
    end

endmodule
